// File: rtl/gcd_scheduler_if.sv
// Request/response bus between the GCD requesters and the shared scheduler.
// The requester side is the master; the scheduler is the slave.
interface gcd_scheduler_if #(
    parameter int NREQ = 4,
    parameter int IDW  = 2,
    parameter int W    = 16
) ();
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic [NREQ-1:0]   req_ready;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IDW-1:0]    rsp_id;
    logic [W-1:0]      rsp_gcd;
    logic              rsp_err;

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_gcd, rsp_err
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_gcd, rsp_err
    );
endinterface

// File: rtl/gcd_scheduler.sv
// Round-robin scheduler that time-shares one subtractive GCD datapath among
// NREQ requesters, sequencing the subtract loop from the comparator flags.
module gcd_scheduler #(
    parameter int NREQ     = 4,
    parameter int IDW      = 2,
    parameter int W        = 16,
    parameter int MAX_ITER = 65535
) (
    input  logic             clk,
    input  logic             rst,
    gcd_scheduler_if.slave   bus,
    input  logic             lt,
    input  logic             gt,
    input  logic             eq,
    input  logic [W-1:0]     a_out,
    output logic             ld_a,
    output logic             ld_b,
    output logic             sel1,
    output logic             sel2,
    output logic             sel_in,
    output logic [W-1:0]     data_in
);
    localparam int CW = $clog2(MAX_ITER + 1);
    localparam logic [CW-1:0] ITER_LIMIT = CW'(MAX_ITER);

    typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_B, CALC, RESP} state_e;

    state_e         state_q, state_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic [IDW-1:0] id_q, id_d;
    logic [W-1:0]   a_q, a_d;
    logic [W-1:0]   b_q, b_d;
    logic [W-1:0]   result_q, result_d;
    logic           err_q, err_d;
    logic [CW-1:0]  cnt_q, cnt_d;

    logic           found;
    logic [IDW-1:0] winner;
    logic [W-1:0]   winA, winB;
    logic           calcStep;

    // Search from ptr upward first, then wrap around to the indices below it.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        winA   = '0;
        winB   = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!found && i >= int'(ptr_q) && bus.req_valid[i]) begin
                found  = 1'b1;
                winner = IDW'(i);
                winA   = bus.req_a[i*W +: W];
                winB   = bus.req_b[i*W +: W];
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!found && i < int'(ptr_q) && bus.req_valid[i]) begin
                found  = 1'b1;
                winner = IDW'(i);
                winA   = bus.req_a[i*W +: W];
                winB   = bus.req_b[i*W +: W];
            end
        end
    end

    assign calcStep = (state_q == CALC) && !eq && (cnt_q != ITER_LIMIT) && (lt || gt);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            id_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            id_q     <= id_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        id_d     = id_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        err_d    = err_q;
        cnt_d    = cnt_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    a_d  = winA;
                    b_d  = winB;
                    id_d = winner;
                    // A zero operand makes the GCD the other operand; skip the datapath.
                    if (winA == '0 || winB == '0) begin
                        result_d = winA | winB;
                        err_d    = 1'b0;
                        state_d  = RESP;
                    end else begin
                        state_d  = LOAD_A;
                    end
                end
            end
            LOAD_A: state_d = LOAD_B;
            LOAD_B: begin
                cnt_d   = '0;
                state_d = CALC;
            end
            CALC: begin
                if (eq) begin
                    result_d = a_out;
                    err_d    = 1'b0;
                    state_d  = RESP;
                end else if (cnt_q == ITER_LIMIT) begin
                    result_d = '0;
                    err_d    = 1'b1;
                    state_d  = RESP;
                end else if (calcStep) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    ptr_d   = (id_q == IDW'(NREQ - 1)) ? '0 : id_q + 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready = '0;
        bus.rsp_valid = 1'b0;
        ld_a          = 1'b0;
        ld_b          = 1'b0;
        sel1          = 1'b0;
        sel2          = 1'b0;
        sel_in        = 1'b0;
        data_in       = '0;
        if (!rst) begin
            case (state_q)
                IDLE: begin
                    if (found) bus.req_ready = {{(NREQ-1){1'b0}}, 1'b1} << winner;
                end
                LOAD_A: begin
                    sel_in  = 1'b1;
                    data_in = a_q;
                    ld_a    = 1'b1;
                end
                LOAD_B: begin
                    sel_in  = 1'b1;
                    data_in = b_q;
                    ld_b    = 1'b1;
                end
                CALC: begin
                    if (calcStep) begin
                        if (lt) begin
                            sel1 = 1'b1;
                            ld_b = 1'b1;
                        end else begin
                            sel2 = 1'b1;
                            ld_a = 1'b1;
                        end
                    end
                end
                RESP: bus.rsp_valid = 1'b1;
                default: ;
            endcase
        end
    end

    assign bus.rsp_id  = id_q;
    assign bus.rsp_gcd = result_q;
    assign bus.rsp_err = err_q;
endmodule

// File: tb/tb_gcd_scheduler.sv
// Directed bench for gcd_scheduler with a behavioural subtractive datapath
// and a response scoreboard filled in grant order.
module tb_gcd_scheduler;
    localparam int NREQ = 4;
    localparam int IDW  = 2;
    localparam int W    = 16;
    localparam int MAXI = 8;

    typedef struct packed {
        logic [IDW-1:0] id;
        logic [W-1:0]   gcd;
        logic           err;
    } rsp_t;

    rsp_t sbQ[$];
    rsp_t expRsp;
    int   compared   = 0;
    int   mismatched = 0;
    int   ldCount    = 0;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         lt, gt, eq;
    logic         ldA, ldB, sel1, sel2, selIn;
    logic [W-1:0] dataIn, regA, regB, opL, opR, dpBus;

    gcd_scheduler_if #(.NREQ(NREQ), .IDW(IDW), .W(W)) busIf ();

    gcd_scheduler #(.NREQ(NREQ), .IDW(IDW), .W(W), .MAX_ITER(MAXI)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (busIf),
        .lt      (lt),
        .gt      (gt),
        .eq      (eq),
        .a_out   (regA),
        .ld_a    (ldA),
        .ld_b    (ldB),
        .sel1    (sel1),
        .sel2    (sel2),
        .sel_in  (selIn),
        .data_in (dataIn)
    );

    initial forever #5 clk = ~clk;

    // Shared datapath: operand muxes, subtractor, bus mux, A/B registers, comparator.
    assign opL   = sel1 ? regB : regA;
    assign opR   = sel2 ? regB : regA;
    assign dpBus = selIn ? dataIn : (opL - opR);
    assign lt    = regA < regB;
    assign gt    = regA > regB;
    assign eq    = regA == regB;

    always @(posedge clk) begin
        if (ldA) regA <= dpBus;
        if (ldB) regB <= dpBus;
        if (ldA || ldB) ldCount <= ldCount + 1;
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference GCD with the same iteration cap the DUT is built with.
    task automatic gcdModel(input logic [W-1:0] a, input logic [W-1:0] b,
                            output logic [W-1:0] g, output logic e, output int k);
        logic [W-1:0] x, y;
        k = 0;
        e = 1'b0;
        g = a | b;
        if (a != 0 && b != 0) begin
            x = a;
            y = b;
            while (x != y && !e) begin
                if (k == MAXI) begin
                    e = 1'b1;
                end else begin
                    if (x < y) y = y - x;
                    else       x = x - y;
                    k++;
                end
            end
            g = e ? '0 : x;
        end
    endtask

    always @(negedge clk) begin
        if (!rst && busIf.rsp_valid && busIf.rsp_ready) begin
            if (sbQ.size() == 0) begin
                checkOutput("unexpected_rsp", 32'(busIf.rsp_valid), 32'd0);
            end else begin
                expRsp = sbQ.pop_front();
                checkOutput("rsp_id",  32'(busIf.rsp_id),  32'(expRsp.id));
                checkOutput("rsp_gcd", 32'(busIf.rsp_gcd), 32'(expRsp.gcd));
                checkOutput("rsp_err", 32'(busIf.rsp_err), 32'(expRsp.err));
            end
        end
    end

    task automatic applyStimulus(input int id, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input bit expectRsp, output int expLat);
        rsp_t         r;
        logic [W-1:0] g;
        logic         e;
        int           k;
        busIf.req_valid[id]       = 1'b1;
        busIf.req_a[id*W +: W]    = a;
        busIf.req_b[id*W +: W]    = b;
        gcdModel(a, b, g, e, k);
        expLat = (a == 0 || b == 0) ? 1 : 4 + k;
        if (expectRsp) begin
            r.id  = IDW'(id);
            r.gcd = g;
            r.err = e;
            sbQ.push_back(r);
        end
    endtask

    task automatic waitGrant(input string tag, input logic [NREQ-1:0] exp);
        int n = 0;
        @(negedge clk);
        while (busIf.req_ready == 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        checkOutput(tag, 32'(busIf.req_ready), 32'(exp));
        @(posedge clk);
        #1;
    endtask

    task automatic waitResp(input string tag, input int expLat);
        int lat = 1;
        @(negedge clk);
        while (!busIf.rsp_valid && lat < 300) begin
            @(negedge clk);
            lat++;
        end
        checkOutput(tag, 32'(lat), 32'(expLat));
    endtask

    task automatic checkQuiet(input string tag);
        checkOutput({tag, "_ctrl"}, 32'({busIf.req_ready, busIf.rsp_valid, busIf.rsp_err,
                                          ldA, ldB, sel1, sel2, selIn, busIf.rsp_id}), 32'd0);
        checkOutput({tag, "_data"}, {busIf.rsp_gcd, dataIn}, 32'd0);
    endtask

    task automatic runJob(input string tag, input int id, input logic [W-1:0] a,
                          input logic [W-1:0] b, input int expLds);
        int lat;
        int snap;
        @(posedge clk);
        #1;
        applyStimulus(id, a, b, 1'b1, lat);
        waitGrant({tag, "_grant"}, NREQ'(1) << id);
        busIf.req_valid[id] = 1'b0;
        snap = ldCount;
        waitResp({tag, "_lat"}, lat);
        if (expLds >= 0) checkOutput({tag, "_loads"}, 32'(ldCount - snap), 32'(expLds));
        @(posedge clk);
    endtask

    initial begin
        int lat;
        int rrLat[4];
        busIf.req_valid = '0;
        busIf.req_a     = '0;
        busIf.req_b     = '0;
        busIf.rsp_ready = 1'b0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        checkQuiet("reset");
        @(posedge clk);
        #1;
        rst             = 1'b0;
        busIf.rsp_ready = 1'b1;
        @(negedge clk);
        checkQuiet("post_reset");

        runJob("single", 0, 16'd143, 16'd78, -1);
        runJob("zero_a", 1, 16'd0,   16'd21, 0);
        runJob("zeros",  2, 16'd0,   16'd0,  0);
        runJob("equal",  3, 16'd42,  16'd42, 2);
        runJob("timeout", 0, 16'd100, 16'd1, 10);
        runJob("after_to", 1, 16'd12, 16'd18, -1);

        // Backpressure with a competing requester waiting.
        @(posedge clk);
        #1;
        busIf.rsp_ready = 1'b0;
        applyStimulus(2, 16'd35, 16'd14, 1'b1, lat);
        applyStimulus(3, 16'd4,  16'd6,  1'b1, rrLat[3]);
        waitGrant("bp_grant", 4'b0100);
        busIf.req_valid[2] = 1'b0;
        waitResp("bp_lat", lat);
        for (int i = 0; i < 5; i++) begin
            checkOutput("bp_valid", 32'(busIf.rsp_valid), 32'd1);
            checkOutput("bp_gcd",   32'(busIf.rsp_gcd),   32'd7);
            checkOutput("bp_id",    32'(busIf.rsp_id),    32'd2);
            checkOutput("bp_ready", 32'(busIf.req_ready), 32'd0);
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        busIf.rsp_ready = 1'b1;
        waitGrant("bp_next_grant", 4'b1000);
        busIf.req_valid[3] = 1'b0;
        waitResp("bp_next_lat", rrLat[3]);
        @(posedge clk);

        // Reset in the middle of a long job; the requests below are held through reset.
        @(posedge clk);
        #1;
        applyStimulus(0, 16'd65535, 16'd1, 1'b0, lat);
        waitGrant("abort_grant", 4'b0001);
        busIf.req_valid[0] = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        applyStimulus(0, 16'd9,  16'd6,  1'b1, rrLat[0]);
        applyStimulus(2, 16'd15, 16'd10, 1'b1, rrLat[1]);
        applyStimulus(3, 16'd8,  16'd12, 1'b1, rrLat[2]);
        applyStimulus(0, 16'd9,  16'd6,  1'b1, rrLat[3]);
        @(posedge clk);
        @(negedge clk);
        checkQuiet("mid_reset");
        @(posedge clk);
        #1;
        rst = 1'b0;

        waitGrant("rr_grant0", 4'b0001);
        waitResp("rr_lat0", rrLat[0]);
        @(posedge clk);
        waitGrant("rr_grant1", 4'b0100);
        waitResp("rr_lat1", rrLat[1]);
        @(posedge clk);
        waitGrant("rr_grant2", 4'b1000);
        waitResp("rr_lat2", rrLat[2]);
        @(posedge clk);
        waitGrant("rr_grant3", 4'b0001);
        busIf.req_valid = '0;
        waitResp("rr_lat3", rrLat[3]);
        @(posedge clk);

        runJob("post_abort", 1, 16'd48, 16'd18, -1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("sb_empty", 32'(sbQ.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule

// File: doc/gcd_scheduler.md
# gcd_scheduler

Shares one subtractive GCD datapath (A/B registers, operand muxes, subtractor, comparator) among NREQ requesters. Arbitrates round-robin, loads operands onto the datapath bus, sequences the subtract loop from the comparator flags, and returns the tagged result. Sits between requesting blocks and the datapath, replacing the datapath's standalone controller.

## Interface
- NREQ, 4: number of requesters (2..8)
- IDW, 2: requester ID width, equal to ceil(log2(NREQ))
- W, 16: operand/result width
- MAX_ITER, 65535: maximum CALC cycles before abort
- clk  in  1  clock; all state changes on posedge
- rst  in  1  reset; synchronous and active-high
- req_valid  in  NREQ  per-requester request; held with its operands until accepted
- req_a  in  NREQ*W  operand A, requester i at bits [i*W +: W]
- req_b  in  NREQ*W  operand B, same packing
- req_ready  out  NREQ  one-hot accept strobe
- rsp_valid  out  1  result available
- rsp_ready  in  1  result consumer ready
- rsp_id  out  IDW  requester index of the result
- rsp_gcd  out  W  GCD result
- rsp_err  out  1  result aborted on MAX_ITER
- lt, gt, eq  in  1 each  datapath comparator flags: A<B, A>B, A==B
- a_out  in  W  datapath A register
- ld_a, ld_b  out  1 each  datapath register loads
- sel1, sel2  out  1 each  subtractor operand selects (0 = A, 1 = B)
- sel_in  out  1  bus select (1 = data_in, 0 = subtractor)
- data_in  out  W  operand driven onto the bus

## Operation
- States: IDLE, LOAD_A, LOAD_B, CALC, RESP.
- IDLE: winner = first asserted req_valid at or above ptr, wrapping modulo NREQ. req_ready[winner]=1 combinationally; latch a, b and id on that edge.
  - If a==0 or b==0: result <= a|b (0 when both are zero), err <= 0, next state RESP. The datapath is not used.
  - Otherwise: next state LOAD_A.
- LOAD_A: sel_in=1, data_in=a, ld_a=1. Next: LOAD_B.
- LOAD_B: sel_in=1, data_in=b, ld_b=1. Next: CALC. Clear the iteration counter.
- CALC: decoded from the current flags.
  - eq: result <= a_out, err <= 0, next RESP. No loads.
  - lt: sel1=1, sel2=0, sel_in=0, ld_b=1 (B <= B-A).
  - gt: sel1=0, sel2=1, sel_in=0, ld_a=1 (A <= A-B).
  - Counter increments on each lt/gt cycle. If counter == MAX_ITER and eq is low: result <= 0, err <= 1, next RESP, no load that cycle.
- RESP: rsp_valid=1; rsp_gcd, rsp_id and rsp_err are driven from the latched registers and held stable. On rsp_valid&&rsp_ready: ptr <= (id+1) mod NREQ, next IDLE.
- Default outputs in every state: ld_a, ld_b, sel1, sel2, sel_in = 0; data_in = 0; req_ready = 0 outside IDLE.
- Exactly one job is in flight. No new request is accepted until the RESP handshake completes.

## Timing
- Reset: state=IDLE, ptr=0, counter=0, result=0, err=0, id=0.
  - All outputs 0 during and after reset until a request arrives.
  - Reset mid-job aborts it with no response. The datapath registers are not reset; the next job reloads both.
- Flags are valid the cycle after each load. CALC never samples flags in the same cycle as a load.
- Latency from the accept edge (cycle 0):
  - Datapath path: LOAD_A at 1, LOAD_B at 2, CALC from 3, rsp_valid at 3+k+1, where k = number of subtractions.
  - Zero bypass: rsp_valid at 1.
  - Equal operands (k=0): rsp_valid at 4.
- rsp_ready may be held high in advance; with no backpressure, the earliest next accept is the cycle after the RESP handshake.
- Simultaneous requests: one grant per job, rotating. Non-winners see req_ready=0 and must hold their request.
- A requester deasserting req_valid before accept is legal; requests are not retained.

## Test plan
- Single job: req 0 with (143,78) -> req_ready[0] at cycle 0, six subtractions, rsp_valid at cycle 10 with rsp_gcd=13, rsp_id=0, rsp_err=0.
- Round-robin: reqs 0, 2 and 3 held valid from reset with rsp_ready=1 -> grant order 0, 2, 3, 0. Each result matches its requester's GCD and carries the correct rsp_id.
- Zero and equal operands: (0,21) -> rsp_gcd=21 at cycle 1 with no ld_a/ld_b activity. (0,0) -> 0. (42,42) -> 42 at cycle 4.
- Timeout: MAX_ITER=8 with (100,1) -> rsp_err=1 and rsp_gcd=0 after 8 CALC loads; the next job (12,18) returns 6 with rsp_err=0.
- Backpressure: rsp_ready low for 5 cycles during RESP -> rsp_valid, rsp_gcd and rsp_id held stable, req_ready stays 0, ptr unchanged until the handshake.
- Reset mid-CALC on (65535,1) -> next cycle state is IDLE with all outputs 0 and no response. A following (48,18) returns 6.
